// File: rtl/trim_pwm_mc_if.sv
// Register-side bundle for the multi-channel trim PWM: enable, shadow write
// strobes and the registered PWM/terminal-count outputs.
interface trim_pwm_mc_if #(
   parameter int Resolution = 8,
   parameter int Channels   = 4
);
   logic                  en;
   logic                  period_wr;
   logic [Resolution-1:0] period_data;
   logic                  cmp_wr;
   logic [2:0]            cmp_sel;
   logic [Resolution-1:0] cmp_data;
   logic [Channels-1:0]   pwm;
   logic                  tc;

   modport master (
      output en, period_wr, period_data, cmp_wr, cmp_sel, cmp_data,
      input  pwm, tc
   );

   modport slave (
      input  en, period_wr, period_data, cmp_wr, cmp_sel, cmp_data,
      output pwm, tc
   );
endinterface

// File: rtl/trim_pwm_mc.sv
// Multi-channel trim PWM: one shared period counter (edge or center aligned)
// feeding Channels double-buffered "count < compare" outputs.
module trim_pwm_mc_ch #(
   parameter int Resolution = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en_i,
   input  logic                  bnd_i,
   input  logic                  wr_i,
   input  logic [Resolution-1:0] data_i,
   input  logic [Resolution-1:0] count_i,
   output logic                  pwm_o
);
   logic [Resolution-1:0] cmp_sh_q, cmp_sh_d, cmp_act_q;
   logic                  pwm_q;

   // A write landing on the boundary cycle is passed straight into active.
   always_comb cmp_sh_d = wr_i ? data_i : cmp_sh_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cmp_sh_q  <= '0;
         cmp_act_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         cmp_sh_q <= cmp_sh_d;
         if (bnd_i) cmp_act_q <= cmp_sh_d;
         if (en_i)  pwm_q     <= (count_i < cmp_act_q);
      end
   end

   assign pwm_o = pwm_q;
endmodule

module trim_pwm_mc #(
   parameter int Resolution  = 8,
   parameter int Channels    = 4,
   parameter int CenterAlign = 0
) (
   input  logic          clock,
   input  logic          reset,
   trim_pwm_mc_if.slave  bus
);
   localparam logic [Resolution-1:0] ONE = Resolution'(1);

   logic [Resolution-1:0] count_q, count_d;
   logic [Resolution-1:0] per_sh_q, per_sh_d, per_act_q, per_nxt;
   logic                  dir_q, dir_d;   // 1 = counting down
   logic                  tc_q, bnd;
   logic [Channels-1:0]   pwm_w;

   always_comb begin
      per_sh_d = bus.period_wr ? bus.period_data : per_sh_q;
      if (CenterAlign != 0)
         bnd = bus.en && ((per_act_q == '0) || (count_q == '0 && dir_q));
      else
         bnd = bus.en && (count_q == per_act_q);
      per_nxt = bnd ? per_sh_d : per_act_q;
      count_d = count_q;
      dir_d   = dir_q;
      if (CenterAlign == 0) begin
         count_d = (count_q == per_act_q) ? '0 : count_q + ONE;
      end else if (count_q == '0) begin
         // Valley: the next sweep climbs under whichever period is now active.
         count_d = (per_nxt == '0) ? '0 : ONE;
         dir_d   = 1'b0;
      end else if (!dir_q && count_q >= per_act_q) begin
         count_d = count_q - ONE;
         dir_d   = 1'b1;
      end else if (!dir_q) begin
         count_d = count_q + ONE;
      end else begin
         count_d = count_q - ONE;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         dir_q     <= 1'b0;
         per_sh_q  <= '1;
         per_act_q <= '1;
         tc_q      <= 1'b0;
      end else begin
         per_sh_q <= per_sh_d;
         if (bnd) per_act_q <= per_sh_d;
         if (bus.en) begin
            count_q <= count_d;
            dir_q   <= dir_d;
         end
         tc_q <= bnd;
      end
   end

   for (genvar i = 0; i < Channels; i++) begin : g_ch
      trim_pwm_mc_ch #(.Resolution(Resolution)) u_ch (
         .clock   (clock),
         .reset   (reset),
         .en_i    (bus.en),
         .bnd_i   (bnd),
         .wr_i    (bus.cmp_wr && (bus.cmp_sel == 3'(i))),
         .data_i  (bus.cmp_data),
         .count_i (count_q),
         .pwm_o   (pwm_w[i])
      );
   end

   assign bus.pwm = pwm_w;
   assign bus.tc  = tc_q;
endmodule

// File: tb/tb_trim_pwm_mc.sv
// Drives an edge-aligned and a center-aligned instance with identical random
// traffic and compares both against a phase-based period model.
module tb_trim_pwm_mc;
   localparam int RES = 8;
   localparam int CH  = 4;

   logic           clock = 1'b0;
   logic           reset;
   logic           en, period_wr, cmp_wr;
   logic [RES-1:0] period_data, cmp_data;
   logic [2:0]     cmp_sel;

   int errs = 0;
   int checks = 0;

   always #5 clock = ~clock;

   trim_pwm_mc_if #(.Resolution(RES), .Channels(CH)) ife ();
   trim_pwm_mc_if #(.Resolution(RES), .Channels(CH)) ifc ();

   assign ife.en = en;           assign ifc.en = en;
   assign ife.period_wr = period_wr;     assign ifc.period_wr = period_wr;
   assign ife.period_data = period_data; assign ifc.period_data = period_data;
   assign ife.cmp_wr = cmp_wr;   assign ifc.cmp_wr = cmp_wr;
   assign ife.cmp_sel = cmp_sel; assign ifc.cmp_sel = cmp_sel;
   assign ife.cmp_data = cmp_data;       assign ifc.cmp_data = cmp_data;

   trim_pwm_mc #(.Resolution(RES), .Channels(CH), .CenterAlign(0)) u_edge (
      .clock(clock), .reset(reset), .bus(ife.slave));
   trim_pwm_mc #(.Resolution(RES), .Channels(CH), .CenterAlign(1)) u_ctr (
      .clock(clock), .reset(reset), .bus(ifc.slave));

   // Model: each period is a run of phases 0..len-1; boundary at the last phase.
   int unsigned pa [2], ps [2], ph [2];
   bit          nob [2];
   int unsigned ca [2][CH], cs [2][CH];
   logic [CH-1:0] xp [2];
   logic          xt [2];

   function automatic int unsigned plen(int m, int unsigned p);
      if (p == 0) return 1;
      return (m != 0) ? 2 * p : p + 1;
   endfunction

   function automatic int unsigned pcnt(int m, int unsigned p, int unsigned t);
      if (m == 0) return t;
      if (p == 0) return 0;
      return (t < p) ? t + 1 : 2 * p - 1 - t;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         pa[m] = (1 << RES) - 1;
         ps[m] = pa[m];
         for (int i = 0; i < CH; i++) begin ca[m][i] = 0; cs[m][i] = 0; end
         ph[m]  = (m != 0) ? plen(m, pa[m]) - 1 : 0;
         nob[m] = (m != 0);
         xp[m]  = '0;
         xt[m]  = 1'b0;
      end
   endtask

   task automatic model_step(input int m);
      int unsigned len, cnt;
      bit b;
      len = plen(m, pa[m]);
      cnt = pcnt(m, pa[m], ph[m]);
      b = en && (ph[m] == len - 1) && !nob[m];
      if (en) begin
         for (int i = 0; i < CH; i++) xp[m][i] = (cnt < ca[m][i]);
         xt[m] = b;
      end else xt[m] = 1'b0;
      if (period_wr) ps[m] = period_data;
      if (cmp_wr && cmp_sel < CH) cs[m][cmp_sel] = cmp_data;
      if (b) begin
         pa[m] = ps[m];
         for (int i = 0; i < CH; i++) ca[m][i] = cs[m][i];
         ph[m] = 0;
      end else if (en) begin
         ph[m]  = (ph[m] + 1) % len;
         nob[m] = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      model_step(0);
      model_step(1);
      @(negedge clock);
      chk("pwm_edge", 32'(ife.pwm), 32'(xp[0]));
      chk("tc_edge",  32'(ife.tc),  32'(xt[0]));
      chk("pwm_ctr",  32'(ifc.pwm), 32'(xp[1]));
      chk("tc_ctr",   32'(ifc.tc),  32'(xt[1]));
   endtask

   task automatic idle();
      period_wr = 1'b0; cmp_wr = 1'b0;
   endtask

   task automatic rnd_inputs();
      en          = ($urandom_range(0, 99) < 85);
      period_wr   = ($urandom_range(0, 19) == 0);
      period_data = RES'($urandom_range(0, 12));
      cmp_wr      = ($urandom_range(0, 3) == 0);
      cmp_sel     = 3'($urandom_range(0, 7));
      cmp_data    = RES'($urandom_range(0, 14));
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; idle();
      period_data = '0; cmp_data = '0; cmp_sel = '0;
      model_reset();
      @(negedge clock);
      chk("rst_pwm_edge", 32'(ife.pwm), 32'(0));
      chk("rst_tc_edge",  32'(ife.tc),  32'(0));
      chk("rst_pwm_ctr",  32'(ifc.pwm), 32'(0));
      chk("rst_tc_ctr",   32'(ifc.tc),  32'(0));
      reset = 1'b0; en = 1'b1;

      // Default period after reset: full-range counting, all outputs low.
      repeat (600) cyc();

      repeat (3000) begin rnd_inputs(); cyc(); end

      // Constant-high channel 0, then an asynchronous reset between edges.
      en = 1'b1; idle();
      period_wr = 1'b1; period_data = RES'(9);
      cmp_wr = 1'b1; cmp_sel = 3'd0; cmp_data = RES'(200);
      cyc(); idle();
      repeat (40) cyc();
      chk("pre_rst_pwm0_edge", 32'(ife.pwm[0]), 32'(1));
      chk("pre_rst_pwm0_ctr",  32'(ifc.pwm[0]), 32'(1));
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("arst_pwm_edge", 32'(ife.pwm), 32'(xp[0]));
      chk("arst_tc_edge",  32'(ife.tc),  32'(xt[0]));
      chk("arst_pwm_ctr",  32'(ifc.pwm), 32'(xp[1]));
      chk("arst_tc_ctr",   32'(ifc.tc),  32'(xt[1]));
      @(negedge clock);
      reset = 1'b0;
      repeat (600) cyc();

      repeat (500) begin rnd_inputs(); cyc(); end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
